// File: rtl/gpu_dispatch_pkg.sv
// Shared types for the GPU job dispatcher and its descriptor FIFO.
package gpu_dispatch_pkg;

  localparam int ADDR_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    logic [ADDR_W-1:0] c;
  } gpu_job_t;

endpackage

// File: rtl/gpu_job_fifo.sv
// Synchronous descriptor FIFO; pointers carry an extra MSB so full and empty
// are distinguished without a separate flag.
module gpu_job_fifo
  import gpu_dispatch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  gpu_job_t      din,
  output gpu_job_t      dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  gpu_job_t    mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // Advance pointers on accepted push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  end

  // Pointer registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Descriptor storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/gpu_job_dispatcher.sv
// Buffers matrix-job descriptors and issues them round-robin to free GPU
// units with a one-cycle start pulse; counts completions and reports idle.
module gpu_job_dispatcher
  import gpu_dispatch_pkg::*;
#(
  parameter  int NUM_UNITS  = 8,
  parameter  int FIFO_DEPTH = 4,
  parameter  int CNT_WIDTH  = 16,
  localparam int UW         = $clog2(NUM_UNITS),
  localparam int FCW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [ADDR_W-1:0]    job_a,
  input  logic [ADDR_W-1:0]    job_b,
  input  logic [ADDR_W-1:0]    job_c,
  input  logic [NUM_UNITS-1:0] unit_busy,
  output logic [NUM_UNITS-1:0] unit_start,
  output logic [ADDR_W-1:0]    matrix_a [NUM_UNITS],
  output logic [ADDR_W-1:0]    matrix_b [NUM_UNITS],
  output logic [ADDR_W-1:0]    matrix_c [NUM_UNITS],
  output logic [CNT_WIDTH-1:0] jobs_done,
  output logic                 all_idle,
  output logic [FCW-1:0]       fifo_count
);

  // Returns {found, unit}: first set bit of free scanning from ptr upward.
  function automatic logic [UW:0] rr_pick(input logic [NUM_UNITS-1:0] free,
                                          input logic [UW-1:0]        ptr);
    logic [UW:0] res;
    int          idx;
    res = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_UNITS) idx -= NUM_UNITS;
      if (free[UW'(idx)]) res = {1'b1, UW'(idx)};
    end
    return res;
  endfunction

  gpu_job_t             head;
  logic                 fifo_full, fifo_empty, push, dispatch;
  logic [NUM_UNITS-1:0] free, falls;
  logic [UW:0]          pick;
  logic [UW-1:0]        pick_u;
  int                   rr_nxt;

  logic [NUM_UNITS-1:0] pending_q, pending_d;
  logic [NUM_UNITS-1:0] busy_q;
  logic [NUM_UNITS-1:0] unit_start_q, unit_start_d;
  logic [UW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0] jobs_done_q, jobs_done_d;
  logic                 all_idle_q, all_idle_d;
  logic [ADDR_W-1:0]    matrix_a_q [NUM_UNITS], matrix_a_d [NUM_UNITS];
  logic [ADDR_W-1:0]    matrix_b_q [NUM_UNITS], matrix_b_d [NUM_UNITS];
  logic [ADDR_W-1:0]    matrix_c_q [NUM_UNITS], matrix_c_d [NUM_UNITS];

  assign job_ready = !rst && !fifo_full;
  assign push      = job_valid && job_ready;

  gpu_job_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (dispatch),
    .din   ('{a: job_a, b: job_b, c: job_c}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Pick a free unit, build dispatch updates, and accumulate completions.
  always_comb begin
    free         = ~unit_busy & ~pending_q;
    pick         = rr_pick(free, rr_ptr_q);
    pick_u       = pick[UW-1:0];
    dispatch     = !fifo_empty && pick[UW];
    pending_d    = pending_q & ~unit_busy;
    unit_start_d = '0;
    matrix_a_d   = matrix_a_q;
    matrix_b_d   = matrix_b_q;
    matrix_c_d   = matrix_c_q;
    rr_ptr_d     = rr_ptr_q;
    rr_nxt       = int'(pick_u) + 1;
    if (rr_nxt >= NUM_UNITS) rr_nxt = 0;
    if (dispatch) begin
      pending_d[pick_u]    = 1'b1;
      unit_start_d[pick_u] = 1'b1;
      matrix_a_d[pick_u]   = head.a;
      matrix_b_d[pick_u]   = head.b;
      matrix_c_d[pick_u]   = head.c;
      rr_ptr_d             = UW'(rr_nxt);
    end
    falls       = busy_q & ~unit_busy;
    jobs_done_d = jobs_done_q + CNT_WIDTH'($countones(falls));
    all_idle_d  = fifo_empty && (unit_busy == '0) && (pending_q == '0);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= '0;
      busy_q       <= '0;
      unit_start_q <= '0;
      rr_ptr_q     <= '0;
      jobs_done_q  <= '0;
      all_idle_q   <= 1'b1;
      matrix_a_q   <= '{default: '0};
      matrix_b_q   <= '{default: '0};
      matrix_c_q   <= '{default: '0};
    end else begin
      pending_q    <= pending_d;
      busy_q       <= unit_busy;
      unit_start_q <= unit_start_d;
      rr_ptr_q     <= rr_ptr_d;
      jobs_done_q  <= jobs_done_d;
      all_idle_q   <= all_idle_d;
      matrix_a_q   <= matrix_a_d;
      matrix_b_q   <= matrix_b_d;
      matrix_c_q   <= matrix_c_d;
    end
  end

  assign unit_start = unit_start_q;
  assign jobs_done  = jobs_done_q;
  assign all_idle   = all_idle_q;
  assign matrix_a   = matrix_a_q;
  assign matrix_b   = matrix_b_q;
  assign matrix_c   = matrix_c_q;

endmodule

// File: tb/tb_gpu_job_dispatcher.sv
// Bench for gpu_job_dispatcher: queue-based reference model checked every
// cycle, a small compute-array emulator driving unit_busy, and directed
// scenarios with literal expectations.
module tb_gpu_job_dispatcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [31:0] job_a = '0, job_b = '0, job_c = '0;
  logic [7:0]  unit_busy = '0;
  logic [7:0]  unit_start;
  logic [31:0] matrix_a [8];
  logic [31:0] matrix_b [8];
  logic [31:0] matrix_c [8];
  logic [15:0] jobs_done;
  logic        all_idle;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad   = 0;

  gpu_job_dispatcher #(.NUM_UNITS(8), .FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_a(job_a), .job_b(job_b), .job_c(job_c), .unit_busy(unit_busy),
    .unit_start(unit_start), .matrix_a(matrix_a), .matrix_b(matrix_b),
    .matrix_c(matrix_c), .jobs_done(jobs_done), .all_idle(all_idle),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- compute-array emulator ----------------
  logic [7:0] man_busy  = '0;
  logic [7:0] auto_busy = '0;
  bit         auto_en   = 1'b0;
  int         tmr [8]   = '{default: 0};
  int         start_log [$];

  always begin
    @(negedge clk); #1;
    for (int u = 0; u < 8; u++) begin
      auto_busy[u] = auto_en && (tmr[u] > 0);
      if (tmr[u] > 0) tmr[u]--;
      if (unit_start[u]) begin
        tmr[u] = 2;
        start_log.push_back(u);
      end
    end
    unit_busy = auto_busy | man_busy;
  end

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] c; } mjob_t;
  mjob_t       mq [$];
  logic [7:0]  m_pend, m_start, m_bprev;
  logic [31:0] m_a [8], m_b [8], m_c [8];
  logic [15:0] m_done;
  logic        m_idle;
  int          m_rr;

  task automatic model_step();
    int         sz0, uf, u;
    logic [7:0] pend0;
    bit         acc;
    if (rst) begin
      mq.delete();
      m_pend = '0; m_start = '0; m_bprev = '0; m_done = '0; m_idle = 1'b1; m_rr = 0;
      for (int k = 0; k < 8; k++) begin m_a[k] = '0; m_b[k] = '0; m_c[k] = '0; end
    end else begin
      sz0   = mq.size();
      pend0 = m_pend;
      acc   = job_valid && (sz0 < 4);
      uf    = -1;
      if (sz0 > 0)
        for (int k = 0; k < 8; k++) begin
          u = (m_rr + k) % 8;
          if (uf < 0 && !unit_busy[u] && !pend0[u]) uf = u;
        end
      m_start = '0;
      m_pend  = pend0 & ~unit_busy;
      m_idle  = (sz0 == 0) && (unit_busy == 8'h00) && (pend0 == 8'h00);
      m_done  = m_done + 16'($countones(m_bprev & ~unit_busy));
      m_bprev = unit_busy;
      if (uf >= 0) begin
        m_pend[uf]  = 1'b1;
        m_start[uf] = 1'b1;
        m_a[uf] = mq[0].a; m_b[uf] = mq[0].b; m_c[uf] = mq[0].c;
        void'(mq.pop_front());
        m_rr = (uf + 1) % 8;
      end
      if (acc) mq.push_back('{job_a, job_b, job_c});
    end
  endtask

  // Step the model at each edge and compare all outputs shortly after.
  always begin
    @(posedge clk);
    model_step();
    #2;
    chk("unit_start", 32'(unit_start), 32'(m_start));
    chk("jobs_done",  32'(jobs_done),  32'(m_done));
    chk("all_idle",   32'(all_idle),   32'(m_idle));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("job_ready",  32'(job_ready),  32'(!rst && (mq.size() < 4)));
    for (int u = 0; u < 8; u++) begin
      chk($sformatf("matrix_a[%0d]", u), matrix_a[u], m_a[u]);
      chk($sformatf("matrix_b[%0d]", u), matrix_b[u], m_b[u]);
      chk($sformatf("matrix_c[%0d]", u), matrix_c[u], m_c[u]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #3;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk); rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_job(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input int max_wait, output bit ok);
    int i;
    @(negedge clk);
    job_valid = 1'b1; job_a = a; job_b = b; job_c = c;
    ok = 1'b0; i = 0;
    while (!ok && i < max_wait) begin
      ok = job_ready;
      @(negedge clk);
      i++;
    end
    job_valid = 1'b0;
  endtask

  task automatic wait_start(input int max, output logic [7:0] s);
    bit seen = 1'b0;
    s = '0;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      if (unit_start != 8'h00) begin seen = 1'b1; s = unit_start; end
    end
    chk("start_within_bound", 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      if (all_idle) seen = 1'b1;
    end
    chk("idle_within_bound", 32'(seen), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    bit         ok;
    logic [7:0] s;
    int         n0;

    // Reset then idle
    repeat (2) @(negedge clk);
    tick();
    chk("rst_ready_low", 32'(job_ready), 32'd0);
    chk("rst_start",     32'(unit_start), 32'd0);
    chk("rst_count",     32'(fifo_count), 32'd0);
    chk("rst_done",      32'(jobs_done), 32'd0);
    chk("rst_idle",      32'(all_idle), 32'd1);
    @(negedge clk); rst = 1'b0; #1;
    chk("ready_after_rst", 32'(job_ready), 32'd1);

    // Single job to unit 0, then next job to unit 1
    auto_en = 1'b1;
    push_job(32'h1000, 32'h2000, 32'h3000, 10, ok);
    chk("single_accept", 32'(ok), 32'd1);
    wait_start(10, s);
    chk("single_start", 32'(s), 32'h01);
    chk("single_ma0", matrix_a[0], 32'h1000);
    chk("single_mb0", matrix_b[0], 32'h2000);
    chk("single_mc0", matrix_c[0], 32'h3000);
    tick();
    chk("single_pulse_one_cycle", 32'(unit_start), 32'd0);
    push_job(32'h1100, 32'h2100, 32'h3100, 10, ok);
    wait_start(10, s);
    chk("rr_advanced", 32'(s), 32'h02);
    chk("single_ma0_held", matrix_a[0], 32'h1000);
    wait_idle(20);

    // Round-robin wrap with 9 jobs
    do_reset(1);
    start_log.delete();
    for (int j = 0; j < 9; j++) begin
      push_job(32'h4000 + 32'(j), 32'h5000 + 32'(j), 32'h6000 + 32'(j), 20, ok);
      chk("rr_accept", 32'(ok), 32'd1);
    end
    wait_idle(40);
    chk("rr_count", 32'(start_log.size()), 32'd9);
    for (int j = 0; j < 9 && j < start_log.size(); j++)
      chk($sformatf("rr_order[%0d]", j), 32'(start_log[j]), 32'(j % 8));
    chk("rr_ma0_job9", matrix_a[0], 32'h4008);
    chk("rr_mc7_job8", matrix_c[7], 32'h6007);

    // Backpressure
    do_reset(1);
    @(negedge clk); man_busy = 8'hFF;
    for (int j = 0; j < 4; j++) begin
      push_job(32'h7000 + 32'(j), 32'h8000 + 32'(j), 32'h9000 + 32'(j), 10, ok);
      chk("bp_accept", 32'(ok), 32'd1);
    end
    push_job(32'h7004, 32'h8004, 32'h9004, 4, ok);
    chk("bp_5th_rejected", 32'(ok), 32'd0);
    tick();
    chk("bp_ready_low", 32'(job_ready), 32'd0);
    chk("bp_count_full", 32'(fifo_count), 32'd4);
    @(negedge clk); man_busy = 8'hF7;
    wait_start(10, s);
    chk("bp_unit3_start", 32'(s), 32'h08);
    chk("bp_unit3_job1", matrix_a[3], 32'h7000);
    chk("bp_ready_back", 32'(job_ready), 32'd1);
    @(negedge clk); man_busy = 8'h00;
    wait_idle(40);

    // Simultaneous falls on units 2 and 5
    do_reset(1);
    auto_en = 1'b0;
    @(negedge clk); man_busy = 8'h24;
    @(negedge clk); man_busy = 8'h00;
    tick();
    chk("done_plus2", 32'(jobs_done), 32'd2);

    // Counter wrap
    do_reset(1);
    for (int k = 0; k < 8191; k++) begin
      @(negedge clk); man_busy = 8'hFF;
      @(negedge clk); man_busy = 8'h00;
    end
    @(negedge clk); man_busy = 8'h7F;
    @(negedge clk); man_busy = 8'h00;
    tick();
    chk("done_ffff", 32'(jobs_done), 32'h0000FFFF);
    @(negedge clk); man_busy = 8'h01;
    @(negedge clk); man_busy = 8'h00;
    tick();
    chk("done_wrap", 32'(jobs_done), 32'h00000000);

    // Mid-operation reset
    do_reset(1);
    @(negedge clk); man_busy = 8'hFF;
    for (int j = 0; j < 3; j++) begin
      push_job(32'hA000 + 32'(j), 32'hB000, 32'hC000, 10, ok);
      chk("mid_accept", 32'(ok), 32'd1);
    end
    tick();
    chk("mid_queued", 32'(fifo_count), 32'd3);
    n0 = start_log.size();
    @(negedge clk); rst = 1'b1; man_busy = 8'h01;
    @(negedge clk); rst = 1'b0;
    repeat (4) tick();
    chk("mid_flushed", 32'(fifo_count), 32'd0);
    @(negedge clk); man_busy = 8'h00;
    tick();
    chk("mid_done_counted", 32'(jobs_done), 32'd1);
    repeat (3) tick();
    chk("mid_no_starts", 32'(start_log.size()), 32'(n0));
    chk("mid_idle", 32'(all_idle), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpu_job_dispatcher.md
Name: gpu_job_dispatcher

Overview:
Sits directly upstream of gpu_compute_array, between the RISC-V core's GPU-offload path and the per-unit start/operand ports. Accepts matrix-job descriptors (A/B/C base addresses) over a valid/ready handshake and buffers them in a FIFO. Issues each job to a free GPU unit in round-robin order with a one-cycle start pulse. Counts completions and reports global idle.

Parameters:
NUM_UNITS, 8, number of GPU compute units driven
FIFO_DEPTH, 4, job descriptor queue depth (power of two, >=2)
CNT_WIDTH, 16, width of completed-job counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
job_valid  in  1  descriptor valid
job_ready  out  1  descriptor accepted when valid&&ready
job_a  in  32  matrix A base address
job_b  in  32  matrix B base address
job_c  in  32  matrix C (result) base address
unit_busy  in  NUM_UNITS  per-unit busy from compute array
unit_start  out  NUM_UNITS  one-cycle start pulse per unit
matrix_a  out  32 x NUM_UNITS  per-unit A address (unpacked array)
matrix_b  out  32 x NUM_UNITS  per-unit B address
matrix_c  out  32 x NUM_UNITS  per-unit C address
jobs_done  out  CNT_WIDTH  completed-job count, wraps
all_idle  out  1  queue empty, no unit busy or pending
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: job_ready=0 during rst, 1 the first cycle after; unit_start=0; matrix_a/b/c=0; jobs_done=0; fifo_count=0; all_idle=1. FIFO, pending mask, and rr_ptr (=0) cleared.
- Accept: job_ready = !full, registered-independent (combinational from count). A push while full is impossible. There is no bypass, so an accepted job is never dispatched in its acceptance cycle.
- Free unit: free[u] = !unit_busy[u] && !pending[u].
- Pending: pending[u] is set at dispatch to u and cleared in any cycle where unit_busy[u]=1. This covers the one-cycle gap before the array raises busy. Units raise busy the cycle after start.
- Dispatch (single per cycle): if FIFO non-empty and any free unit exists, pick the first free u scanning rr_ptr, rr_ptr+1, ... modulo NUM_UNITS.
  - At that edge: pop head; register unit_start[u]=1 (high exactly one cycle); load matrix_a/b/c[u] from head; rr_ptr <= (u+1) mod NUM_UNITS.
  - matrix_x[u] holds until the next dispatch to u.
  - Other units' starts remain 0.
- Latency: job accepted at edge N causes unit_start high during cycle N+1..N+2 (earliest) when a unit is free.
- Simultaneous push and pop: both occur; count unchanged. Push while full and popping in the same cycle is not allowed (ready is already low).
- No free unit: head waits; job_ready follows occupancy only.
- Completion: busy_q <= unit_busy. Each falling edge (busy_q[u] && !unit_busy[u]) increments jobs_done by one. Multiple simultaneous falls increment by popcount. Overflow wraps modulo 2^CNT_WIDTH.
- all_idle (registered) = fifo empty && unit_busy==0 && pending==0.
- Reset mid-operation: queued jobs discarded and pending cleared. Units already running are not stopped. Their later busy falling edge is counted, because busy_q is 0 out of reset and samples 1 first.

Decomposition:
- Package gpu_dispatch_pkg: typedef gpu_job_t packed struct {a, b, c} (96 bits); localparam ADDR_W=32.
- Sub-module gpu_job_fifo: synchronous FIFO of gpu_job_t, depth FIFO_DEPTH, push/pop/full/empty/count, pointer wrap via extra MSB.
- Round-robin picker stays inline as a function.

Test Plan:
- Reset then idle: rst high 3 cycles -> all outputs 0, all_idle=1, job_ready=1 after release.
- Single job: push a=0x1000,b=0x2000,c=0x3000 with all units idle -> unit_start=8'b0000_0001 for exactly one cycle; matrix_a[0]=0x1000, b=0x2000, c=0x3000; rr_ptr advances to 1.
- Round-robin wrap: push 9 jobs while the model drops busy after 2 cycles -> starts hit units 0..7, then unit 0 again; no unit gets two starts while pending/busy.
- Backpressure: hold unit_busy=8'hFF, push 5 jobs -> 4 accepted, job_ready=0, fifo_count=4. Release busy[3] -> unit 3 starts with job 1, job_ready returns 1.
- Completion counting: busy falls on units 2 and 5 in the same cycle -> jobs_done +2. Preload counter to 0xFFFF via 65535 completions, one more -> 0x0000.
- Mid-op reset: 3 jobs queued, unit 0 busy, assert rst one cycle -> fifo_count=0, no further starts. Unit 0 busy falling afterwards -> jobs_done=1.
